// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
// Display-side model of an HD44780-style 8-bit LCD bus. It decodes
// instruction and data writes, keeps the address counter (AC) and an
// 80-byte DDRAM, models the busy flag, and answers status and data reads.
// A second read port lets a bench or loop-back checker look at DDRAM.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active low
//   i_rs         register select: 0 = instruction/status, 1 = data
//   i_rw         1 = read, 0 = write
//   i_en         bus strobe, asynchronous to i_clk
//   i_din        write data from the controller
//   o_dout       read data returned to the controller
//   o_dout_oe    high while a read strobe is active
//   o_busy       busy flag
//   o_ac         address counter
//   o_disp_on    display-on bit (D)
//   o_cursor_on  cursor bit (C)
//   o_blink_on   blink bit (B)
//   o_two_line   N bit from function set
//   o_err        one-cycle pulse when a write arrives while busy
//   i_mon_addr   DDRAM monitor address (same address map as AC)
//   o_mon_data   DDRAM[i_mon_addr], one cycle latency, 0x00 if unmapped
//
// Bus FSM
//   state    | meaning
//   S_IDLE   | waiting for a strobe rise
//   S_STROBE | strobe high, rs/rw/din latched, read data driven
//   S_COMMIT | cycle after fall detect; the access takes effect here

module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 160,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic       i_en,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_dout_oe,
    output logic       o_busy,
    output logic [6:0] o_ac,
    output logic       o_disp_on,
    output logic       o_cursor_on,
    output logic       o_blink_on,
    output logic       o_two_line,
    output logic       o_err,
    input  logic [6:0] i_mon_addr,
    output logic [7:0] o_mon_data
);

    localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_COMMIT} state_t;

    // AC 0x00..0x27 -> index 0..39, AC 0x40..0x67 -> index 40..79.
    function automatic logic f_mapped(input logic [6:0] a);
        return a[6] ? (a <= 7'h67) : (a <= 7'h27);
    endfunction

    function automatic logic [6:0] f_index(input logic [6:0] a);
        return a[6] ? (a - 7'd24) : a;
    endfunction

    // Unmapped addresses step as if they were the last mapped address of
    // their line (0x27 or 0x67).
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a >= 7'h67)                    n = 7'h00;
            else if (a >= 7'h27 && a < 7'h40) n = 7'h40;
            else                               n = a + 7'd1;
        end else begin
            if (a == 7'h00)                    n = 7'h67;
            else if (a == 7'h40)               n = 7'h27;
            else if (a >= 7'h68)               n = 7'h66;
            else if (a >= 7'h28 && a < 7'h40) n = 7'h26;
            else                               n = a - 7'd1;
        end
        return n;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SS-1:0]   r_en_sync;
    logic            r_en_dly;
    logic            w_rise;
    logic            w_fall;
    logic            w_latch;
    logic            w_commit;
    logic            w_oe_clr;

    logic            r_rs;
    logic            r_rw;
    logic [7:0]      r_din;
    logic [7:0]      r_dout;
    logic            r_dout_oe;
    logic [6:0]      r_ac;
    logic            r_id;
    logic            r_s;
    logic            r_disp_on;
    logic            r_cursor_on;
    logic            r_blink_on;
    logic            r_two_line;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic            r_sweep_on;
    logic [6:0]      r_sweep_idx;
    logic            w_busy;

    logic [7:0]      r_ddram [80];
    logic [7:0]      r_mon_data;
    logic            w_mem_we;
    logic [6:0]      w_mem_idx;
    logic [7:0]      w_mem_wdata;
    logic [7:0]      w_rd_data;

    // Display shift is not modelled; S is held only so it reads back sanely.
    logic            w_unused_s;
    assign w_unused_s = r_s;

    assign w_busy = (r_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_en_sync <= '0;
            r_en_dly  <= 1'b0;
        end else begin
            r_en_sync <= {r_en_sync[SS-2:0], i_en};
            r_en_dly  <= r_en_sync[SS-1];
        end
    end

    assign w_rise = r_en_sync[SS-1] & ~r_en_dly;
    assign w_fall = ~r_en_sync[SS-1] & r_en_dly;

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        w_oe_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                if (w_fall) begin
                    w_oe_clr    = 1'b1;
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                if (w_rise) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_STROBE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_rd_data = f_mapped(r_ac) ? r_ddram[f_index(r_ac)] : 8'h00;

    // The clear sweep only runs while busy, and writes are refused while
    // busy, so the two never compete for the write port.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = r_sweep_idx;
        w_mem_wdata = 8'h20;
        if (r_sweep_on) begin
            w_mem_we = 1'b1;
        end else if (w_commit && !r_rw && r_rs && !w_busy && f_mapped(r_ac)) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = f_index(r_ac);
            w_mem_wdata = r_din;
        end
    end

    // DDRAM survives reset; a write on the reset edge is dropped so a
    // sweep interrupted by reset stops exactly where it was.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_mem_we) r_ddram[w_mem_idx] <= w_mem_wdata;
        r_mon_data <= f_mapped(i_mon_addr) ? r_ddram[f_index(i_mon_addr)] : 8'h00;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rs        <= 1'b0;
            r_rw        <= 1'b0;
            r_din       <= 8'h00;
            r_dout      <= 8'h00;
            r_dout_oe   <= 1'b0;
            r_ac        <= 7'h00;
            r_id        <= 1'b1;
            r_s         <= 1'b0;
            r_disp_on   <= 1'b0;
            r_cursor_on <= 1'b0;
            r_blink_on  <= 1'b0;
            r_two_line  <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_sweep_on  <= 1'b0;
            r_sweep_idx <= 7'd0;
        end else begin
            r_err <= 1'b0;
            if (w_busy) r_cnt <= r_cnt - 1'b1;

            if (r_sweep_on) begin
                if (r_sweep_idx == 7'd79) r_sweep_on  <= 1'b0;
                else                      r_sweep_idx <= r_sweep_idx + 7'd1;
            end

            if (w_latch) begin
                r_rs  <= i_rs;
                r_rw  <= i_rw;
                r_din <= i_din;
                if (i_rw) begin
                    r_dout_oe <= 1'b1;
                    r_dout    <= i_rs ? w_rd_data : {w_busy, r_ac};
                end
            end
            if (w_oe_clr) r_dout_oe <= 1'b0;

            if (w_commit) begin
                if (!r_rw) begin
                    if (w_busy) begin
                        r_err <= 1'b1;
                    end else if (r_rs) begin
                        r_ac  <= f_step(r_ac, r_id);
                        r_cnt <= CW'(BUSY_CYCLES);
                    end else begin
                        casez (r_din)
                            8'b1???????: begin
                                r_ac  <= r_din[6:0];
                                r_cnt <= CW'(BUSY_CYCLES);
                            end
                            8'b01??????: r_cnt <= CW'(BUSY_CYCLES);
                            8'b001?????: begin
                                r_two_line <= r_din[3];
                                r_cnt      <= CW'(BUSY_CYCLES);
                            end
                            8'b0001????: r_cnt <= CW'(BUSY_CYCLES);
                            8'b00001???: begin
                                r_disp_on   <= r_din[2];
                                r_cursor_on <= r_din[1];
                                r_blink_on  <= r_din[0];
                                r_cnt       <= CW'(BUSY_CYCLES);
                            end
                            8'b000001??: begin
                                r_id  <= r_din[1];
                                r_s   <= r_din[0];
                                r_cnt <= CW'(BUSY_CYCLES);
                            end
                            8'b0000001?: begin
                                r_ac  <= 7'h00;
                                r_cnt <= CW'(CLEAR_CYCLES);
                            end
                            8'b00000001: begin
                                r_ac        <= 7'h00;
                                r_id        <= 1'b1;
                                r_sweep_on  <= 1'b1;
                                r_sweep_idx <= 7'd0;
                                r_cnt       <= CW'(CLEAR_CYCLES);
                            end
                            default: ;
                        endcase
                    end
                end else if (r_rs) begin
                    // Data reads step AC; a read during a longer busy
                    // period (e.g. a clear) must not shorten it.
                    r_ac <= f_step(r_ac, r_id);
                    if (!w_busy) r_cnt <= CW'(BUSY_CYCLES);
                end
            end
        end
    end

    assign o_dout      = r_dout;
    assign o_dout_oe   = r_dout_oe;
    assign o_busy      = w_busy;
    assign o_ac        = r_ac;
    assign o_disp_on   = r_disp_on;
    assign o_cursor_on = r_cursor_on;
    assign o_blink_on  = r_blink_on;
    assign o_two_line  = r_two_line;
    assign o_err       = r_err;
    assign o_mon_data  = r_mon_data;

endmodule
